mem_port_arbiter: RTL and testbench

Arbiter sharing the single-port unified memory between the instruction-fetch port and the load/store data port of the ARM processor. It grants one requester per access, drives the shared memory address, write-data and write-enable lines, and returns registered read data with a one-cycle acknowledge. It sits between the core's fetch/data interfaces and the memory-plus-peripheral block, and enables the multicycle core to run on one memory.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and shared-memory signal bundle for mem_port_arbiter.
// slave = arbiter view; master = core + memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_we;
  logic          m_im;
  logic [DW-1:0] m_rd;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rd,
    output i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wd, m_we, m_im
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rd,
    input  i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wd, m_we, m_im
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data ports; ack + rdata two cycles after req is sampled.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise data always wins ties.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t        state;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          tie_to_d;

  logic [AW-1:0] m_addr_c;
  logic [DW-1:0] m_wd_c;
  logic          m_we_c;
  logic          m_im_c;

`ifdef MEM_ARB_RR_EN
  logic last_d;
  assign tie_to_d = ~last_d;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.d_req && (!bus.i_req || tie_to_d))
            state <= SERVE_D;
          else if (bus.i_req)
            state <= SERVE_I;
        end
        SERVE_I: begin
          i_rdata_q <= bus.m_rd;
          i_ack_q   <= 1'b1;
          state     <= DONE;
`ifdef MEM_ARB_RR_EN
          last_d    <= 1'b0;
`endif
        end
        SERVE_D: begin
          d_rdata_q <= bus.m_rd;
          d_ack_q   <= 1'b1;
          state     <= DONE;
`ifdef MEM_ARB_RR_EN
          last_d    <= 1'b1;
`endif
        end
        DONE: begin
          // The ack still high tells us who was just served; only the other port may chain.
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (d_ack_q && bus.i_req)
            state <= SERVE_I;
          else if (i_ack_q && bus.d_req)
            state <= SERVE_D;
          else
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory controls decode straight from the state register so reset kills m_we at once.
  always_comb begin
    m_addr_c = '0;
    m_wd_c   = '0;
    m_we_c   = 1'b0;
    m_im_c   = 1'b0;
    case (state)
      SERVE_I: begin
        m_addr_c = {bus.i_addr[AW-1:2], 2'b00};
        m_im_c   = 1'b1;
      end
      SERVE_D: begin
        m_addr_c = {bus.d_addr[AW-1:2], 2'b00};
        m_wd_c   = bus.d_wdata;
        m_we_c   = bus.d_we;
      end
      default: ;
    endcase
  end

  assign bus.m_addr  = m_addr_c;
  assign bus.m_wd    = m_wd_c;
  assign bus.m_we    = m_we_c;
  assign bus.m_im    = m_im_c;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign busy        = (state != IDLE);

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural word memory on the shared port.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic busy;
  int   ntests = 0;
  int   nfail  = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initv(input int k);
    if (k == 2) return 32'hE3A0_1005;
    return 32'hA500_0000 ^ (32'(k) * 32'h0001_0101);
  endfunction

  logic [31:0] mem [0:1023];
  logic [31:0] model [0:1023];
  logic        mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) mem[k] <= initv(k);
      mem_ready <= 1'b1;
    end else if (bus.m_we) begin
      mem[bus.m_addr[11:2]] <= bus.m_wd;
    end
  end
  assign bus.m_rd = mem[bus.m_addr[11:2]];

  logic [31:0] exp_i [$];
  logic [31:0] exp_d [$];
  bit          ord_q [$];

  task automatic apply_reset();
    reset = 1'b1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    exp_i.delete(); exp_d.delete(); ord_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ntests++; if (bus.i_ack !== 1'b0) begin nfail++; $display("FAIL reset_i_ack: got %b want 0", bus.i_ack); end
    ntests++; if (bus.d_ack !== 1'b0) begin nfail++; $display("FAIL reset_d_ack: got %b want 0", bus.d_ack); end
    ntests++; if (bus.i_rdata !== 32'h0) begin nfail++; $display("FAIL reset_i_rdata: got %h want 0", bus.i_rdata); end
    ntests++; if (bus.d_rdata !== 32'h0) begin nfail++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
    ntests++; if (bus.m_we !== 1'b0 || bus.m_im !== 1'b0) begin nfail++; $display("FAIL reset_mem_ctl: got we=%b im=%b want 0 0", bus.m_we, bus.m_im); end
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
    ntests++; if (bus.m_addr !== 32'h0) begin nfail++; $display("FAIL reset_m_addr: got %h want 0", bus.m_addr); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_fetch();
    logic [31:0] e;
    @(posedge clk);
    #1 bus.i_req = 1'b1; bus.i_addr = 32'h0000_0008;
    exp_i.push_back(model[2]);
    @(negedge clk);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL fetch_idle_busy: got %b want 0", busy); end
    @(negedge clk);
    ntests++; if (bus.m_addr !== 32'h8 || bus.m_im !== 1'b1 || bus.m_we !== 1'b0) begin nfail++; $display("FAIL fetch_serve: got addr=%h im=%b we=%b want 8 1 0", bus.m_addr, bus.m_im, bus.m_we); end
    ntests++; if (bus.i_ack !== 1'b0) begin nfail++; $display("FAIL fetch_early_ack: got %b want 0", bus.i_ack); end
    @(negedge clk);
    e = exp_i.pop_front();
    ntests++; if (bus.i_ack !== 1'b1) begin nfail++; $display("FAIL fetch_ack: got %b want 1", bus.i_ack); end
    ntests++; if (bus.i_rdata !== e) begin nfail++; $display("FAIL fetch_rdata: got %h want %h", bus.i_rdata, e); end
    ntests++; if (bus.m_im !== 1'b0 || bus.m_addr !== 32'h0) begin nfail++; $display("FAIL fetch_done_bus: got im=%b addr=%h want 0 0", bus.m_im, bus.m_addr); end
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(negedge clk);
    ntests++; if (bus.i_ack !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL fetch_after: got ack=%b busy=%b want 0 0", bus.i_ack, busy); end
    ntests++; if (bus.i_rdata !== e) begin nfail++; $display("FAIL fetch_rdata_hold: got %h want %h", bus.i_rdata, e); end
  endtask

  task automatic test_store();
    int wecnt;
    logic [31:0] e;
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0403; bus.d_wdata = 32'h1234_5678;
    model[256] = 32'h1234_5678;
    wecnt = 0;
    @(negedge clk);
    wecnt += int'(bus.m_we);
    @(negedge clk);
    wecnt += int'(bus.m_we);
    ntests++; if (bus.m_addr !== 32'h400 || bus.m_wd !== 32'h1234_5678 || bus.m_im !== 1'b0) begin nfail++; $display("FAIL store_serve: got addr=%h wd=%h im=%b want 400 12345678 0", bus.m_addr, bus.m_wd, bus.m_im); end
    ntests++; if (bus.m_we !== 1'b1) begin nfail++; $display("FAIL store_we: got %b want 1", bus.m_we); end
    @(negedge clk);
    wecnt += int'(bus.m_we);
    ntests++; if (bus.d_ack !== 1'b1) begin nfail++; $display("FAIL store_ack: got %b want 1", bus.d_ack); end
    @(posedge clk);
    #1 bus.d_we = 1'b0; bus.d_wdata = 32'h0;
    exp_d.push_back(model[256]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      wecnt += int'(bus.m_we);
    end
    ntests++; if (wecnt !== 1) begin nfail++; $display("FAIL store_we_cycles: got %0d want 1", wecnt); end
    e = exp_d.pop_front();
    ntests++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== e) begin nfail++; $display("FAIL store_readback: got ack=%b data=%h want 1 %h", bus.d_ack, bus.d_rdata, e); end
    @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask

  task automatic test_tie_order();
    int nack;
    int last_cyc;
    bit e;
    logic [31:0] x;
    apply_reset();
    bus.i_addr = 32'h10; bus.d_addr = 32'h24; bus.d_we = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ord_q.push_back(k % 2 == 0);
      if (k % 2 == 0) exp_d.push_back(model[9]); else exp_i.push_back(model[4]);
    end
    @(posedge clk);
    #1 bus.i_req = 1'b1; bus.d_req = 1'b1;
    nack = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 40 && nack < 6; cyc++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        e = ord_q.pop_front();
        ntests++; if (bus.d_ack !== e || bus.i_ack !== !e) begin nfail++; $display("FAIL tie_order[%0d]: got i=%b d=%b want d=%b", nack, bus.i_ack, bus.d_ack, e); end
        x = e ? exp_d.pop_front() : exp_i.pop_front();
        ntests++; if ((e ? bus.d_rdata : bus.i_rdata) !== x) begin nfail++; $display("FAIL tie_data[%0d]: got %h want %h", nack, e ? bus.d_rdata : bus.i_rdata, x); end
        if (nack > 0) begin
          ntests++; if (cyc - last_cyc != 2) begin nfail++; $display("FAIL tie_spacing[%0d]: got %0d want 2", nack, cyc - last_cyc); end
        end
        last_cyc = cyc;
        nack++;
        if (nack == 6) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      end
    end
    ntests++; if (nack != 6) begin nfail++; $display("FAIL tie_timeout: got %0d acks want 6", nack); end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL tie_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_tie_after_lone();
    bit want_fetch;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 if (c == 0) bus.i_req = 1'b1; else bus.d_req = 1'b1;
      repeat (3) @(negedge clk);
      ntests++; if ((c == 0 ? bus.i_ack : bus.d_ack) !== 1'b1) begin nfail++; $display("FAIL lone_ack[%0d]: got 0 want 1", c); end
      @(posedge clk);
      #1 bus.i_req = 1'b0; bus.d_req = 1'b0;
      @(posedge clk);
      #1 bus.i_req = 1'b1; bus.d_req = 1'b1;
      want_fetch = (c == 1) && RR;
      repeat (2) @(negedge clk);
      ntests++; if (bus.m_im !== want_fetch || busy !== 1'b1) begin nfail++; $display("FAIL tie_after_lone[%0d]: got im=%b busy=%b want %b 1", c, bus.m_im, busy, want_fetch); end
      @(negedge clk);
      ntests++; if (bus.i_ack !== want_fetch || bus.d_ack !== !want_fetch) begin nfail++; $display("FAIL tie_after_lone_ack[%0d]: got i=%b d=%b want i=%b", c, bus.i_ack, bus.d_ack, want_fetch); end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_d_continuous();
    int nack;
    int last_cyc;
    int nidle;
    logic [31:0] x;
    bus.d_addr = 32'h24; bus.d_we = 1'b0;
    for (int k = 0; k < 4; k++) exp_d.push_back(model[9]);
    @(posedge clk);
    #1 bus.d_req = 1'b1;
    nack = 0; last_cyc = 0; nidle = 0;
    for (int cyc = 0; cyc < 40 && nack < 4; cyc++) begin
      @(negedge clk);
      if (nack > 0 && busy === 1'b0) nidle++;
      if (bus.d_ack === 1'b1) begin
        x = exp_d.pop_front();
        ntests++; if (bus.d_rdata !== x) begin nfail++; $display("FAIL cont_data[%0d]: got %h want %h", nack, bus.d_rdata, x); end
        if (nack > 0) begin
          ntests++; if (cyc - last_cyc != 3) begin nfail++; $display("FAIL cont_spacing[%0d]: got %0d want 3", nack, cyc - last_cyc); end
        end
        last_cyc = cyc;
        nack++;
        if (nack == 4) bus.d_req = 1'b0;
      end
    end
    ntests++; if (nack != 4) begin nfail++; $display("FAIL cont_timeout: got %0d acks want 4", nack); end
    ntests++; if (nidle != 3) begin nfail++; $display("FAIL cont_idle_cycles: got %0d want 3", nidle); end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int nack;
    logic [31:0] x;
    @(posedge clk);
    #1 bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    ntests++; if (bus.m_we !== 1'b1) begin nfail++; $display("FAIL rst_mid_pre_we: got %b want 1", bus.m_we); end
    #1 reset = 1'b1;
    #1;
    ntests++; if (bus.m_we !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL rst_mid_we_drop: got we=%b busy=%b want 0 0", bus.m_we, busy); end
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.d_ack !== 1'b0) nack++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    if (bus.d_ack !== 1'b0) nack++;
    ntests++; if (nack != 0) begin nfail++; $display("FAIL rst_mid_ack: got %0d ack cycles want 0", nack); end
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_mid_idle: got busy=%b want 0", busy); end
    exp_d.push_back(model[8]);
    @(posedge clk);
    #1 bus.d_req = 1'b1;
    repeat (3) @(negedge clk);
    x = exp_d.pop_front();
    ntests++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== x) begin nfail++; $display("FAIL rst_mid_no_write: got ack=%b data=%h want 1 %h", bus.d_ack, bus.d_rdata, x); end
    bus.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] x;
    bus.d_addr = 32'h24; bus.d_we = 1'b0;
    exp_d.push_back(model[9]);
    @(posedge clk);
    #1 bus.d_req = 1'b1;
    repeat (3) @(negedge clk);
    x = exp_d.pop_front();
    ntests++; if (bus.d_ack !== 1'b1 || bus.d_rdata !== x) begin nfail++; $display("FAIL b2b_d: got ack=%b data=%h want 1 %h", bus.d_ack, bus.d_rdata, x); end
    bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h10;
    exp_i.push_back(model[4]);
    @(negedge clk);
    ntests++; if (bus.m_im !== 1'b1 || busy !== 1'b1 || bus.m_addr !== 32'h10) begin nfail++; $display("FAIL b2b_serve_i: got im=%b busy=%b addr=%h want 1 1 10", bus.m_im, busy, bus.m_addr); end
    @(negedge clk);
    x = exp_i.pop_front();
    ntests++; if (bus.i_ack !== 1'b1 || bus.i_rdata !== x) begin nfail++; $display("FAIL b2b_i: got ack=%b data=%h want 1 %h", bus.i_ack, bus.i_rdata, x); end
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(negedge clk);
    ntests++; if (busy !== 1'b0) begin nfail++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    for (int k = 0; k < 1024; k++) model[k] = initv(k);
    test_reset();
    test_fetch();
    test_store();
    test_tie_order();
    test_tie_after_lone();
    test_d_continuous();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
